// File: rtl/fb_pkg.sv
// fb_pkg: shared Wishbone constants, pixel word layout and reader FSM states
package fb_pkg;

   localparam logic [2:0] CTI_INCR   = 3'b010;
   localparam logic [2:0] CTI_END    = 3'b111;
   localparam logic [1:0] BTE_LINEAR = 2'b00;

   typedef struct packed {
      logic        sof;
      logic        eol;
      logic [23:0] rgb;
   } pix_word_t;

   typedef enum logic {IDLE, BURST} state_t;

endpackage

// File: rtl/wshb_if.sv
// wshb_if: 32-bit Wishbone bus bundle carrying its own clock and synchronous reset
interface wshb_if (
   input logic clk,
   input logic rst
);

   logic        cyc;
   logic        stb;
   logic        we;
   logic        ack;
   logic [31:0] adr;
   logic [31:0] dat_ms;
   logic [31:0] dat_sm;
   logic [3:0]  sel;
   logic [2:0]  cti;
   logic [1:0]  bte;

   modport master (
      input  clk, rst, dat_sm, ack,
      output cyc, stb, we, adr, sel, cti, bte, dat_ms
   );

   modport slave (
      input  clk, rst, cyc, stb, we, adr, sel, cti, bte, dat_ms,
      output dat_sm, ack
   );

endinterface

// File: rtl/fb_fifo.sv
// fb_fifo: synchronous first-word-fall-through FIFO with occupancy count
module fb_fifo #(
   parameter int W = 26,
   parameter int D = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_push,
   input  logic [W-1:0]         i_data,
   input  logic                 i_pop,
   output logic [W-1:0]         o_data,
   output logic                 o_full,
   output logic                 o_empty,
   output logic [$clog2(D):0]   o_count
);

   localparam int AW = $clog2(D);
   localparam int CW = AW + 1;

   logic [W-1:0]  r_mem [D];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic          w_wr;
   logic          w_rd;

   assign w_wr    = i_push && !o_full;
   assign w_rd    = i_pop && !o_empty;
   assign o_full  = r_cnt == CW'(D);
   assign o_empty = r_cnt == '0;
   assign o_count = r_cnt;
   assign o_data  = r_mem[r_rp];

   // storage array, no reset needed since count gates visibility
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wp] <= i_data;
   end

   // pointers and occupancy; simultaneous push and pop leave the count unchanged
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         r_wp  <= r_wp + AW'(w_wr);
         r_rp  <= r_rp + AW'(w_rd);
         r_cnt <= r_cnt + CW'(w_wr) - CW'(w_rd);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(i_push && o_full));

endmodule

// File: rtl/fb_reader.sv
// fb_reader: Wishbone burst reader streaming the framebuffer in raster order into a tagged pixel FIFO
module fb_reader
   import fb_pkg::*;
#(
   parameter int          HDISP      = 800,
   parameter int          VDISP      = 480,
   parameter logic [31:0] BASE_ADR   = 32'h0,
   parameter int          BURST_LEN  = 16,
   parameter int          FIFO_DEPTH = 64
) (
   wshb_if.master        wshb_ifm,
   input  logic          fb_en,
   output logic [23:0]   pix_data,
   output logic          pix_sof,
   output logic          pix_eol,
   output logic          pix_valid,
   input  logic          pix_ready
);

   localparam int XW = $clog2(HDISP);
   localparam int YW = $clog2(VDISP);
   localparam int BW = $clog2(BURST_LEN);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_t        r_state;
   state_t        w_next;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [31:0]   r_adr;
   logic [BW-1:0] r_beat;
   logic          w_push;
   logic          w_last;
   logic          w_x_end;
   logic          w_y_end;
   logic          w_go;
   logic          w_full;
   logic          w_empty;
   logic [CW-1:0] w_count;
   pix_word_t     w_din;
   pix_word_t     w_dout;
   logic          w_unused;

   assign w_x_end  = r_x == XW'(HDISP - 1);
   assign w_y_end  = r_y == YW'(VDISP - 1);
   assign w_last   = r_beat == BW'(BURST_LEN - 1);
   assign w_push   = (r_state == BURST) && wshb_ifm.ack;
   assign w_go     = fb_en && (w_count <= CW'(FIFO_DEPTH - BURST_LEN));
   assign w_din    = {(r_x == '0) && (r_y == '0), w_x_end, wshb_ifm.dat_sm[23:0]};
   assign w_unused = ^wshb_ifm.dat_sm[31:24];

   assign wshb_ifm.cyc    = r_state == BURST;
   assign wshb_ifm.stb    = r_state == BURST;
   assign wshb_ifm.we     = 1'b0;
   assign wshb_ifm.sel    = 4'b1111;
   assign wshb_ifm.bte    = BTE_LINEAR;
   assign wshb_ifm.dat_ms = 32'h0;
   assign wshb_ifm.adr    = r_adr;
   assign wshb_ifm.cti    = w_last ? CTI_END : CTI_INCR;

   assign pix_data  = w_dout.rgb;
   assign pix_sof   = w_dout.sof;
   assign pix_eol   = w_dout.eol;
   assign pix_valid = !w_empty;

   // start a burst only when a whole burst of FIFO space is free; leave after the last ack
   always_comb begin
      w_next = r_state;
      w_next = (r_state == IDLE) ? (w_go ? BURST : IDLE) : ((w_push && w_last) ? IDLE : BURST);
   end

   // state register; reset drops cyc/stb at the first edge that sees it
   always_ff @(posedge wshb_ifm.clk) begin
      if (wshb_ifm.rst) r_state <= IDLE;
      else              r_state <= w_next;
   end

   // raster position, address and beat counter advance together on every ack
   always_ff @(posedge wshb_ifm.clk) begin
      if (wshb_ifm.rst) begin
         r_x    <= '0;
         r_y    <= '0;
         r_adr  <= BASE_ADR;
         r_beat <= '0;
      end else if (w_push) begin
         r_beat <= r_beat + BW'(1);
         r_x    <= w_x_end ? '0 : r_x + XW'(1);
         r_y    <= w_x_end ? (w_y_end ? '0 : r_y + YW'(1)) : r_y;
         r_adr  <= (w_x_end && w_y_end) ? BASE_ADR : r_adr + 32'd4;
      end
   end

   fb_fifo #(
      .W ($bits(pix_word_t)),
      .D (FIFO_DEPTH)
   ) u_fifo (
      .clk     (wshb_ifm.clk),
      .rst     (wshb_ifm.rst),
      .i_push  (w_push),
      .i_data  (w_din),
      .i_pop   (pix_valid && pix_ready),
      .o_data  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_fb_reader.sv
// tb_fb_reader: directed scenarios against a memory model that returns dat_sm = adr
module tb_fb_reader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fb_en = 1'b0;
   logic        pix_ready = 1'b0;
   logic [23:0] pix_data;
   logic        pix_sof;
   logic        pix_eol;
   logic        pix_valid;

   int vec = 0;
   int err = 0;
   int ws = 0;
   int wc = 0;

   logic [31:0] b_adr [$];
   logic [2:0]  b_cti [$];
   int          b_bn  [$];
   logic [25:0] px    [$];
   int          n_bursts = 0;
   int          hold_err = 0;
   int          stall_cyc = 0;
   logic        prev_cyc = 1'b0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_adr = '0;
   logic [2:0]  prev_cti = '0;

   wshb_if ifm (.clk(clk), .rst(rst));

   fb_reader #(
      .HDISP      (8),
      .VDISP      (4),
      .BASE_ADR   (32'h100),
      .BURST_LEN  (4),
      .FIFO_DEPTH (8)
   ) dut (
      .wshb_ifm  (ifm),
      .fb_en     (fb_en),
      .pix_data  (pix_data),
      .pix_sof   (pix_sof),
      .pix_eol   (pix_eol),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready)
   );

   always #5 clk = ~clk;

   assign ifm.dat_sm = ifm.adr;
   assign ifm.ack    = ifm.cyc && ifm.stb && (wc == ws);

   always @(posedge clk) wc <= (rst || !ifm.stb || ifm.ack) ? 0 : wc + 1;

   always @(negedge clk) begin
      if (ifm.cyc && !prev_cyc) n_bursts++;
      if (prev_stall && ifm.stb && (ifm.adr !== prev_adr || ifm.cti !== prev_cti)) hold_err++;
      if (ifm.stb && !ifm.ack) stall_cyc++;
      if (ifm.cyc && ifm.stb && ifm.ack) begin
         b_adr.push_back(ifm.adr);
         b_cti.push_back(ifm.cti);
         b_bn.push_back(n_bursts);
      end
      if (pix_valid && pix_ready) px.push_back({pix_sof, pix_eol, pix_data});
      prev_cyc   = ifm.cyc;
      prev_stall = ifm.stb && !ifm.ack;
      prev_adr   = ifm.adr;
      prev_cti   = ifm.cti;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      b_adr.delete();
      b_cti.delete();
      b_bn.delete();
      px.delete();
      n_bursts  = 0;
      hold_err  = 0;
      stall_cyc = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      fb_en = 1'b0;
      pix_ready = 1'b0;
      ws = 0;
      repeat (3) tick();
      rst = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      vec++; if (ifm.cyc !== 1'b0) begin err++; $display("FAIL reset_cyc got=%b want=0", ifm.cyc); end
      vec++; if (ifm.stb !== 1'b0) begin err++; $display("FAIL reset_stb got=%b want=0", ifm.stb); end
      vec++; if (pix_valid !== 1'b0) begin err++; $display("FAIL reset_valid got=%b want=0", pix_valid); end
      vec++; if (ifm.adr !== 32'h100) begin err++; $display("FAIL reset_adr got=%h want=00000100", ifm.adr); end
      vec++; if ({ifm.we, ifm.sel, ifm.bte} !== 7'b0_1111_00) begin err++; $display("FAIL const_we_sel_bte got=%b want=0111100", {ifm.we, ifm.sel, ifm.bte}); end
      vec++; if (ifm.dat_ms !== 32'h0) begin err++; $display("FAIL const_dat_ms got=%h want=0", ifm.dat_ms); end
      do_reset();
   endtask

   task automatic test_frame();
      logic [31:0] ea;
      logic [25:0] ep;
      logic [2:0]  ec;
      fb_en = 1'b1;
      pix_ready = 1'b1;
      for (int i = 0; i < 400 && px.size() < 36; i++) tick();
      vec++;
      if (px.size() < 36) begin
         err++; $display("FAIL frame_timeout got=%0d pixels want>=36", px.size());
      end else begin
         for (int i = 0; i < 36; i++) begin
            ea = 32'h100 + 32'(4 * (i % 32));
            ec = (i % 4 == 3) ? 3'b111 : 3'b010;
            ep = {(i % 32) == 0, (i % 8) == 7, ea[23:0]};
            vec++; if (b_adr[i] !== ea) begin err++; $display("FAIL frame_adr[%0d] got=%h want=%h", i, b_adr[i], ea); end
            vec++; if (b_cti[i] !== ec) begin err++; $display("FAIL frame_cti[%0d] got=%b want=%b", i, b_cti[i], ec); end
            vec++; if (px[i] !== ep) begin err++; $display("FAIL frame_pix[%0d] got=%h want=%h", i, px[i], ep); end
         end
         vec++; if (b_bn[31] !== 8) begin err++; $display("FAIL frame_bursts got=%0d want=8", b_bn[31]); end
         vec++; if (b_bn[32] !== 9) begin err++; $display("FAIL frame_wrap_burst got=%0d want=9", b_bn[32]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] ea;
      logic [25:0] ep;
      do_reset();
      fb_en = 1'b1;
      repeat (50) tick();
      vec++; if (n_bursts !== 2) begin err++; $display("FAIL bp_bursts got=%0d want=2", n_bursts); end
      vec++; if (b_adr.size() !== 8) begin err++; $display("FAIL bp_beats got=%0d want=8", b_adr.size()); end
      vec++; if (ifm.cyc !== 1'b0) begin err++; $display("FAIL bp_cyc got=%b want=0", ifm.cyc); end
      vec++; if ({pix_valid, pix_sof, pix_eol, pix_data} !== {3'b110, 24'h000100}) begin
         err++; $display("FAIL bp_hold got=%b%b%b_%h want=110_000100", pix_valid, pix_sof, pix_eol, pix_data);
      end
      pix_ready = 1'b1;
      for (int i = 0; i < 300 && px.size() < 16; i++) tick();
      vec++;
      if (px.size() < 16) begin
         err++; $display("FAIL bp_timeout got=%0d pixels want>=16", px.size());
      end else begin
         for (int i = 0; i < 16; i++) begin
            ea = 32'h100 + 32'(4 * i);
            ep = {i == 0, (i % 8) == 7, ea[23:0]};
            vec++; if (b_adr[i] !== ea) begin err++; $display("FAIL bp_adr[%0d] got=%h want=%h", i, b_adr[i], ea); end
            vec++; if (px[i] !== ep) begin err++; $display("FAIL bp_pix[%0d] got=%h want=%h", i, px[i], ep); end
         end
      end
   endtask

   task automatic test_wait_states();
      logic [31:0] ea;
      logic [25:0] ep;
      do_reset();
      ws = 2;
      fb_en = 1'b1;
      pix_ready = 1'b1;
      for (int i = 0; i < 400 && px.size() < 8; i++) tick();
      vec++;
      if (px.size() < 8) begin
         err++; $display("FAIL ws_timeout got=%0d pixels want>=8", px.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            ea = 32'h100 + 32'(4 * i);
            ep = {i == 0, i == 7, ea[23:0]};
            vec++; if (px[i] !== ep) begin err++; $display("FAIL ws_pix[%0d] got=%h want=%h", i, px[i], ep); end
            vec++; if (b_cti[i] !== ((i % 4 == 3) ? 3'b111 : 3'b010)) begin err++; $display("FAIL ws_cti[%0d] got=%b", i, b_cti[i]); end
         end
      end
      vec++; if (hold_err !== 0) begin err++; $display("FAIL ws_hold got=%0d changes want=0", hold_err); end
      vec++; if (stall_cyc < 16) begin err++; $display("FAIL ws_stalls got=%0d want>=16", stall_cyc); end
      ws = 0;
   endtask

   task automatic test_reset_mid_burst();
      do_reset();
      fb_en = 1'b1;
      for (int i = 0; i < 50 && b_adr.size() < 2; i++) tick();
      vec++; if (ifm.cyc !== 1'b1 || ifm.adr !== 32'h108) begin err++; $display("FAIL mid_pre got cyc=%b adr=%h want cyc=1 adr=00000108", ifm.cyc, ifm.adr); end
      vec++; if (pix_valid !== 1'b1) begin err++; $display("FAIL mid_pre_valid got=%b want=1", pix_valid); end
      rst = 1'b1;
      tick();
      vec++; if (ifm.cyc !== 1'b0 || ifm.stb !== 1'b0) begin err++; $display("FAIL mid_rst_cyc got=%b%b want=00", ifm.cyc, ifm.stb); end
      vec++; if (pix_valid !== 1'b0) begin err++; $display("FAIL mid_rst_valid got=%b want=0", pix_valid); end
      rst = 1'b0;
      clear_logs();
      pix_ready = 1'b1;
      for (int i = 0; i < 100 && px.size() < 4; i++) tick();
      vec++;
      if (px.size() < 4) begin
         err++; $display("FAIL mid_timeout got=%0d pixels want>=4", px.size());
      end else begin
         vec++; if (b_adr[0] !== 32'h100) begin err++; $display("FAIL mid_restart_adr got=%h want=00000100", b_adr[0]); end
         vec++; if (px[0] !== {2'b10, 24'h000100}) begin err++; $display("FAIL mid_restart_pix got=%h want=2000100", px[0]); end
         vec++; if (b_cti[3] !== 3'b111) begin err++; $display("FAIL mid_restart_cti got=%b want=111", b_cti[3]); end
      end
   endtask

   task automatic test_fb_en_pause();
      do_reset();
      fb_en = 1'b1;
      pix_ready = 1'b1;
      for (int i = 0; i < 50 && b_adr.size() < 1; i++) tick();
      fb_en = 1'b0;
      repeat (30) tick();
      vec++; if (b_adr.size() !== 4) begin err++; $display("FAIL pause_beats got=%0d want=4", b_adr.size()); end
      vec++; if (n_bursts !== 1) begin err++; $display("FAIL pause_bursts got=%0d want=1", n_bursts); end
      vec++; if (ifm.cyc !== 1'b0) begin err++; $display("FAIL pause_cyc got=%b want=0", ifm.cyc); end
      vec++; if (px.size() !== 4) begin err++; $display("FAIL pause_pixels got=%0d want=4", px.size()); end
      clear_logs();
      fb_en = 1'b1;
      for (int i = 0; i < 100 && px.size() < 4; i++) tick();
      vec++;
      if (px.size() < 4) begin
         err++; $display("FAIL pause_timeout got=%0d pixels want>=4", px.size());
      end else begin
         vec++; if (b_adr[0] !== 32'h110) begin err++; $display("FAIL pause_resume_adr got=%h want=00000110", b_adr[0]); end
         vec++; if (b_adr[3] !== 32'h11C) begin err++; $display("FAIL pause_resume_adr3 got=%h want=0000011c", b_adr[3]); end
         vec++; if (px[0] !== {2'b00, 24'h000110}) begin err++; $display("FAIL pause_resume_pix got=%h want=0000110", px[0]); end
         vec++; if (px[3] !== {2'b01, 24'h00011C}) begin err++; $display("FAIL pause_resume_eol got=%h want=100011c", px[3]); end
      end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_backpressure();
      test_wait_states();
      test_reset_mid_burst();
      test_fb_en_pause();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
